sevenseg_scan_engine: RTL and testbench

SEVENSEG_SCAN_ENGINE -- requirements
Module: sevenseg_scan_engine

---
 rtl/sevenseg_scan_engine_if.sv | 30 +++
 rtl/sevenseg_scan_engine.sv | 165 ++++++++++++++++
 tb/tb_sevenseg_scan_engine.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_engine_if.sv
// sevenseg_scan_engine_if: display data in, scan drive out.
// master = display controller, slave = scan engine.
interface sevenseg_scan_engine_if #(
  parameter int NUM_DIGITS = 4,
  parameter int CODE_W     = 5,
  parameter int DIM_W      = 3
);
  logic                         tick_scan;
  logic                         tick_1s;
  logic [NUM_DIGITS*CODE_W-1:0] chars;
  logic [NUM_DIGITS-1:0]        blink_mask;
  logic [NUM_DIGITS-1:0]        dp_mask;
  logic [DIM_W-1:0]             brightness;
  logic [6:0]                   seg;
  logic [NUM_DIGITS-1:0]        an;
  logic                         dp;
  logic                         frame_start;

  modport master (
    output tick_scan, tick_1s, chars,
    output blink_mask, dp_mask, brightness,
    input  seg, an, dp, frame_start
  );

  modport slave (
    input  tick_scan, tick_1s, chars,
    input  blink_mask, dp_mask, brightness,
    output seg, an, dp, frame_start
  );
endinterface

// File: rtl/sevenseg_scan_engine.sv
// sevenseg_scan_engine: multiplexed 7-seg scan, PWM dim, blink.
// Optional SEVENSEG_LZ_SUPPRESS_EN blanks leading zero digits.
module seven_segs_decoder #(
  parameter int CODE_W = 5
) (
  input  logic [CODE_W-1:0] i_code,
  output logic [6:0]        o_seg
);
  logic [7:0] w_c;
  logic [6:0] w_on;

  assign w_c = 8'(i_code);

  // w_on is active-high gfedcba; unknown codes are blank
  always_comb begin
    w_on = 7'h00;
    case (w_c)
      8'd0:  w_on = 7'h3F;
      8'd1:  w_on = 7'h06;
      8'd2:  w_on = 7'h5B;
      8'd3:  w_on = 7'h4F;
      8'd4:  w_on = 7'h66;
      8'd5:  w_on = 7'h6D;
      8'd6:  w_on = 7'h7D;
      8'd7:  w_on = 7'h07;
      8'd8:  w_on = 7'h7F;
      8'd9:  w_on = 7'h6F;
      8'd10: w_on = 7'h77;
      8'd11: w_on = 7'h7C;
      8'd12: w_on = 7'h39;
      8'd13: w_on = 7'h5E;
      8'd14: w_on = 7'h79;
      8'd15: w_on = 7'h71;
      8'd16: w_on = 7'h76;
      8'd17: w_on = 7'h38;
      8'd18: w_on = 7'h73;
      8'd19: w_on = 7'h3E;
      8'd20: w_on = 7'h54;
      8'd21: w_on = 7'h5C;
      8'd22: w_on = 7'h40;
      default: w_on = 7'h00;
    endcase
  end

  assign o_seg = ~w_on;
endmodule

module sevenseg_scan_engine #(
  parameter int NUM_DIGITS = 4,
  parameter int CODE_W     = 5,
  parameter int DIM_W      = 3,
  parameter int BLANK_CODE = 23
) (
  input logic                   clk,
  input logic                   reset,
  sevenseg_scan_engine_if.slave bus
);
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CODE_W-1:0] BLANK = CODE_W'(BLANK_CODE);
  localparam logic [SW-1:0] LAST = SW'(NUM_DIGITS - 1);

  logic [SW-1:0]                r_slot;
  logic [DIM_W-1:0]             r_sub;
  logic                         r_phase;
  logic [NUM_DIGITS*CODE_W-1:0] r_sh_chars;
  logic [NUM_DIGITS-1:0]        r_sh_blink;
  logic [NUM_DIGITS-1:0]        r_sh_dp;
  logic [DIM_W-1:0]             r_sh_bri;
  logic [NUM_DIGITS-1:0]        r_an;
  logic                         r_dp;
  logic [CODE_W-1:0]            r_code;
  logic                         r_frame;

  logic                  w_sub_wrap;
  logic                  w_frame_wrap;
  logic                  w_lit;
  logic [NUM_DIGITS-1:0] w_an_sel;
  logic [CODE_W-1:0]     w_disp [NUM_DIGITS];
  logic [6:0]            w_seg;
`ifdef SEVENSEG_LZ_SUPPRESS_EN
  logic                  w_lead;
`endif

  assign w_sub_wrap   = bus.tick_scan & (&r_sub);
  assign w_frame_wrap = w_sub_wrap & (r_slot == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot     <= '0;
      r_sub      <= '0;
      r_phase    <= 1'b0;
      r_sh_chars <= {NUM_DIGITS{BLANK}};
      r_sh_blink <= '0;
      r_sh_dp    <= '0;
      r_sh_bri   <= '0;
      r_frame    <= 1'b0;
    end else begin
      if (bus.tick_scan)
        r_sub <= r_sub + 1'b1;
      if (w_sub_wrap)
        r_slot <= (r_slot == LAST) ? '0 : r_slot + 1'b1;
      if (bus.tick_1s)
        r_phase <= ~r_phase;
      // shadows only move at the frame boundary
      if (w_frame_wrap) begin
        r_sh_chars <= bus.chars;
        r_sh_blink <= bus.blink_mask;
        r_sh_dp    <= bus.dp_mask;
        r_sh_bri   <= bus.brightness;
      end
      r_frame <= w_frame_wrap;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++)
      w_disp[i] = r_sh_chars[i*CODE_W +: CODE_W];
`ifdef SEVENSEG_LZ_SUPPRESS_EN
    w_lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (w_disp[i] != '0)
        w_lead = 1'b0;
      if (w_lead)
        w_disp[i] = BLANK;
    end
`endif
  end

  // sub == 0 is always dark so adjacent digits never ghost
  assign w_lit = (r_sub != '0) && (r_sub <= r_sh_bri) &&
                 !(r_sh_blink[r_slot] && r_phase);

  always_comb begin
    w_an_sel = '1;
    w_an_sel[r_slot] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_an   <= '1;
      r_dp   <= 1'b1;
      r_code <= BLANK;
    end else if (w_lit) begin
      r_an   <= w_an_sel;
      r_dp   <= ~r_sh_dp[r_slot];
      r_code <= w_disp[r_slot];
    end else begin
      r_an   <= '1;
      r_dp   <= 1'b1;
      r_code <= BLANK;
    end
  end

  seven_segs_decoder #(
    .CODE_W (CODE_W)
  ) u_dec (
    .i_code (r_code),
    .o_seg  (w_seg)
  );

  assign bus.seg         = w_seg;
  assign bus.an          = r_an;
  assign bus.dp          = r_dp;
  assign bus.frame_start = r_frame;
endmodule

// File: tb/tb_sevenseg_scan_engine.sv
// tb_sevenseg_scan_engine: frame-level scoreboard for the scan engine.
// Expected slot results are queued per frame and popped per slot.
module tb_sevenseg_scan_engine;
  localparam int N  = 4;
  localparam int CW = 5;
  localparam int DW = 3;
  localparam int BL = 23;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         nlit;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sevenseg_scan_engine_if #(
    .NUM_DIGITS (N),
    .CODE_W     (CW),
    .DIM_W      (DW)
  ) bus ();

  sevenseg_scan_engine #(
    .NUM_DIGITS (N),
    .CODE_W     (CW),
    .DIM_W      (DW),
    .BLANK_CODE (BL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  logic [4:0] s_chars [N];
  logic [3:0] s_blink;
  logic [3:0] s_dp;
  int         s_bri;
  bit         phase;

  function automatic logic [6:0] seg_of(input int c);
    case (c)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int disp_code(input int s);
    int c;
    c = int'(s_chars[s]);
`ifdef SEVENSEG_LZ_SUPPRESS_EN
    begin
      bit lead;
      lead = 1'b1;
      for (int i = N - 1; i >= s; i--)
        if (s_chars[i] != 5'd0) lead = 1'b0;
      if (s > 0 && lead) c = BL;
    end
`endif
    return c;
  endfunction

  task automatic set_chars(input int d3, input int d2,
                           input int d1, input int d0);
    bus.chars = {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
  endtask

  task automatic clear_shadow();
    for (int i = 0; i < N; i++) s_chars[i] = 5'(BL);
    s_blink = '0;
    s_dp    = '0;
    s_bri   = 0;
    phase   = 1'b0;
  endtask

  task automatic tick(input bit ts, input bit t1);
    bus.tick_scan = ts;
    bus.tick_1s   = t1;
    @(posedge clk);
    #1;
    bus.tick_scan = 1'b0;
    bus.tick_1s   = 1'b0;
  endtask

  task automatic run_frame(input bit gaps, input bit t1_last,
                           input int chg_slot, input logic [19:0] chg);
    exp_t e;
    int   bad, lit, fs_cnt;
    bit   fs_ok, want;
    logic [3:0] one;
    for (int s = 0; s < N; s++) begin
      one    = 4'b0001 << s;
      e.an   = ~one;
      e.seg  = seg_of(disp_code(s));
      e.dp   = ~s_dp[s];
      e.nlit = (s_blink[s] && phase) ? 0 : s_bri;
      q.push_back(e);
    end
    fs_cnt = 0;
    fs_ok  = 1'b0;
    for (int s = 0; s < N; s++) begin
      e   = q.pop_front();
      bad = 0;
      lit = 0;
      for (int j = 0; j < 8; j++) begin
        if (s == chg_slot && j == 4) bus.chars = chg;
        if (gaps) repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0);
        tick(1'b1, t1_last && s == N - 1 && j == 7);
        want = (j >= 1) && (j <= e.nlit);
        if (bus.an !== 4'hF) lit++;
        if (want) begin
          if (bus.an !== e.an || bus.seg !== e.seg || bus.dp !== e.dp)
            bad++;
        end else if (bus.an !== 4'hF || bus.seg !== 7'h7F ||
                     bus.dp !== 1'b1) begin
          bad++;
        end
        if (bus.frame_start === 1'b1) begin
          fs_cnt++;
          if (s == N - 1 && j == 7) fs_ok = 1'b1;
        end
      end
      checks++;
      if (bad != 0)
        $display("FAIL slot%0d_steps: bad=%0d want an=%b seg=%h dp=%b",
                 s, bad, e.an, e.seg, e.dp);
      if (bad != 0) errors++;
      checks++;
      if (lit != e.nlit) begin
        $display("FAIL slot%0d_lit: got %0d want %0d", s, lit, e.nlit);
        errors++;
      end
    end
    checks++;
    if (fs_cnt != 1 || !fs_ok) begin
      $display("FAIL frame_start: count %0d at_end %0d want 1 1",
               fs_cnt, fs_ok);
      errors++;
    end
    for (int i = 0; i < N; i++) s_chars[i] = bus.chars[i*CW +: CW];
    s_blink = bus.blink_mask;
    s_dp    = bus.dp_mask;
    s_bri   = int'(bus.brightness);
    if (t1_last) phase = ~phase;
  endtask

  task automatic frame();
    run_frame(1'b0, 1'b0, -1, 20'd0);
  endtask

  task automatic check_dark(input string nm);
    checks++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1) begin
      $display("FAIL %s: an=%b seg=%h dp=%b want 1111 7f 1",
               nm, bus.an, bus.seg, bus.dp);
      errors++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    check_dark("reset_out");
    checks++;
    if (bus.frame_start !== 1'b0) begin
      $display("FAIL reset_fs: got %b want 0", bus.frame_start);
      errors++;
    end
    reset = 1'b0;
    clear_shadow();
  endtask

  task automatic test_scan();
    set_chars(4, 3, 2, 1);
    bus.brightness = 3'd7;
    frame();
    frame();
  endtask

  task automatic test_brightness();
    bus.brightness = 3'd2;
    bus.dp_mask    = 4'b0101;
    frame();
    frame();
    bus.brightness = 3'd0;
    frame();
    frame();
  endtask

  task automatic test_blink();
    bus.brightness = 3'd7;
    bus.dp_mask    = 4'b0000;
    bus.blink_mask = 4'b0010;
    run_frame(1'b0, 1'b1, -1, 20'd0);
    run_frame(1'b0, 1'b1, -1, 20'd0);
    frame();
  endtask

  task automatic test_shadow();
    run_frame(1'b0, 1'b0, 2, {5'd9, 5'd8, 5'd7, 5'd6});
    frame();
  endtask

  task automatic test_lz();
    set_chars(0, 0, 5, 0);
    frame();
    frame();
  endtask

  task automatic test_back_to_back();
    set_chars(3, 1, 4, 1);
    bus.brightness = 3'd5;
    run_frame(1'b1, 1'b0, -1, 20'd0);
    run_frame(1'b1, 1'b0, -1, 20'd0);
  endtask

  task automatic test_reset_mid();
    set_chars(5, 6, 7, 8);
    bus.brightness = 3'd7;
    repeat (2 * 8 + 3) tick(1'b1, 1'b0);
    reset = 1'b1;
    tick(1'b1, 1'b0);
    check_dark("reset_mid");
    reset = 1'b0;
    clear_shadow();
    frame();
    frame();
  endtask

  initial begin
    reset          = 1'b1;
    bus.tick_scan  = 1'b0;
    bus.tick_1s    = 1'b0;
    bus.chars      = '0;
    bus.blink_mask = '0;
    bus.dp_mask    = '0;
    bus.brightness = '0;
    clear_shadow();
    test_reset();
    test_scan();
    test_brightness();
    test_blink();
    test_shadow();
    test_lz();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
